// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the writeback path.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XZR_IDX    = 31;
    localparam int WB_DATA_W  = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_REQ0,
        OWN_REQ1
    } owner_t;

endpackage

// File: rtl/mux2_cell.sv
// Single-bit 2:1 mux cell; wide muxes are built from instances of this.
module mux2_cell (
    input  logic sel,
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/wb_port_arbiter_rr_grant2.sv
// Combinational 2-way grant: an owner's lock wins while under its hold limit,
// otherwise the round-robin pointer decides contention.
module rr_grant2
    import cpu_pkg::*;
(
    input  logic   valid0,
    input  logic   valid1,
    input  logic   lock0,
    input  logic   lock1,
    input  logic   prio,
    input  logic   hold_ok,
    input  owner_t owner,
    output logic   gnt0,
    output logic   gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
            if (owner == OWN_REQ0 && lock0 && hold_ok) begin
                gnt0 = 1'b1;
            end else if (owner == OWN_REQ1 && lock1 && hold_ok) begin
                gnt1 = 1'b1;
            end else if (prio) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            // A lone requester always wins, even against an idle lock holder.
            gnt0 = valid0;
            gnt1 = valid1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback.
//   owner    | meaning
//   OWN_NONE | no locked burst in progress
//   OWN_REQ0 | req0 holds the port via lock0, hold_cnt grants so far
//   OWN_REQ1 | req1 holds the port via lock1, hold_cnt grants so far
module wb_port_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int MAX_HOLD = 4,
    parameter int ZERO_REG = XZR_IDX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              lock0,
    output logic              ready0,
    input  logic              valid1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic              lock1,
    output logic              ready1,
    output logic              mux_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam int MUX_W = DATA_W + ADDR_W;

    logic              prio;
    owner_t            owner;
    logic [CNT_W-1:0]  hold_cnt;
    logic              sel_q;
    logic              hold_ok;
    logic              gnt0_raw;
    logic              gnt1_raw;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    owner_t            gnt_owner;
    logic              gnt_lock;
    logic [MUX_W-1:0]  mux_a;
    logic [MUX_W-1:0]  mux_b;
    logic [MUX_W-1:0]  mux_y;
    logic [ADDR_W-1:0] sel_addr;

    assign hold_ok = hold_cnt < CNT_W'(MAX_HOLD);

    rr_grant2 u_grant (
        .valid0  (valid0),
        .valid1  (valid1),
        .lock0   (lock0),
        .lock1   (lock1),
        .prio    (prio),
        .hold_ok (hold_ok),
        .owner   (owner),
        .gnt0    (gnt0_raw),
        .gnt1    (gnt1_raw)
    );

    // No handshake may complete while reset is held.
    assign gnt0    = gnt0_raw & ~reset;
    assign gnt1    = gnt1_raw & ~reset;
    assign any_gnt = gnt0 | gnt1;
    assign ready0  = gnt0;
    assign ready1  = gnt1;
    assign mux_sel = any_gnt ? gnt1 : sel_q;

    assign mux_a = {addr0, data0};
    assign mux_b = {addr1, data1};

    for (genvar i = 0; i < MUX_W; i++) begin : g_mux
        mux2_cell u_cell (
            .sel (mux_sel),
            .a   (mux_a[i]),
            .b   (mux_b[i]),
            .y   (mux_y[i])
        );
    end

    assign sel_addr  = mux_y[MUX_W-1 -: ADDR_W];
    assign gnt_owner = gnt1 ? OWN_REQ1 : OWN_REQ0;
    assign gnt_lock  = gnt1 ? lock1 : lock0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio     <= 1'b0;
            owner    <= OWN_NONE;
            hold_cnt <= '0;
            sel_q    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (any_gnt) begin
            prio  <= gnt0;
            sel_q <= gnt1;
            if (owner == gnt_owner) begin
                if (hold_ok) begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                end
            end else begin
                hold_cnt <= CNT_W'(1);
            end
            owner   <= gnt_lock ? gnt_owner : OWN_NONE;
            // Writes to the zero register still handshake but never reach the file.
            wr_en   <= sel_addr != ADDR_W'(ZERO_REG);
            wr_addr <= sel_addr;
            wr_data <= mux_y[DATA_W-1:0];
        end else begin
            owner    <= OWN_NONE;
            hold_cnt <= '0;
            wr_en    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: rule-level arbitration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;
    import cpu_pkg::*;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int MAX_HOLD = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              valid0, valid1, lock0, lock1;
    wb_req_t           req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              ready0, ready1, mux_sel, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    assign addr0 = req0.addr;
    assign data0 = req0.data;
    assign addr1 = req1.addr;
    assign data1 = req1.data;

    wb_port_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_HOLD (MAX_HOLD),
        .ZERO_REG (31)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid0  (valid0),
        .addr0   (addr0),
        .data0   (data0),
        .lock0   (lock0),
        .ready0  (ready0),
        .valid1  (valid1),
        .addr1   (addr1),
        .data1   (data1),
        .lock1   (lock1),
        .ready1  (ready1),
        .mux_sel (mux_sel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Model state: -1 means no owner / no grant.
    int                m_prio  = 0;
    int                m_owner = -1;
    int                m_hold  = 0;
    int                m_sel   = 0;
    logic              exp_wr_en   = 1'b0;
    logic [ADDR_W-1:0] exp_wr_addr = '0;
    logic [DATA_W-1:0] exp_wr_data = '0;

    function automatic int exp_grant();
        if (reset) return -1;
        if (!valid0 && !valid1) return -1;
        if (valid0 != valid1) return valid0 ? 0 : 1;
        if (m_owner == 0 && lock0 && m_hold < MAX_HOLD) return 0;
        if (m_owner == 1 && lock1 && m_hold < MAX_HOLD) return 1;
        return m_prio;
    endfunction

    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_prio = 0; m_owner = -1; m_hold = 0; m_sel = 0;
            exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
        end else begin
            g = exp_grant();
            if (g < 0) begin
                exp_wr_en = 1'b0;
                m_owner   = -1;
                m_hold    = 0;
            end else begin
                exp_wr_addr = (g == 1) ? req1.addr : req0.addr;
                exp_wr_data = (g == 1) ? req1.data : req0.data;
                exp_wr_en   = (exp_wr_addr != 5'd31);
                m_sel  = g;
                m_prio = 1 - g;
                if (m_owner == g) m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
                else begin
                    m_owner = g;
                    m_hold  = 1;
                end
                if (!((g == 1) ? lock1 : lock0)) m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = exp_grant();
        check("ready0", 64'(ready0), 64'(g == 0));
        check("ready1", 64'(ready1), 64'(g == 1));
        check("ready_onehot", 64'(ready0 && ready1), 64'(0));
        check("mux_sel", 64'(mux_sel), 64'((g < 0) ? m_sel : g));
        check("wr_en", 64'(wr_en), 64'(exp_wr_en));
        check("wr_addr", 64'(wr_addr), 64'(exp_wr_addr));
        check("wr_data", 64'(wr_data), 64'(exp_wr_data));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        valid0 = 1'b0; valid1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        req0 = '0; req1 = '0;
        #2;

        // Reset then idle
        reset = 1'b1;
        valid0 = 1'b1; req0.addr = 5'd3; req0.data = 64'h33;
        obs();
        check("t1_ready0_in_reset", 64'(ready0), 64'(0));
        check("t1_wr_en_in_reset", 64'(wr_en), 64'(0));
        cyc(); reset = 1'b0;
        obs();
        check("t1_ready0_first", 64'(ready0), 64'(1));
        cyc(); valid0 = 1'b0;
        obs();
        check("t1_wr_en", 64'(wr_en), 64'(1));
        check("t1_wr_addr", 64'(wr_addr), 64'(3));

        // Simultaneous single writes
        pulse_reset();
        valid0 = 1'b1; req0.addr = 5'd1; req0.data = 64'hAAAA;
        valid1 = 1'b1; req1.addr = 5'd2; req1.data = 64'h5555;
        obs();
        check("t2_first_ready0", 64'(ready0), 64'(1));
        check("t2_first_ready1", 64'(ready1), 64'(0));
        cyc(); valid0 = 1'b0;
        obs();
        check("t2_second_ready1", 64'(ready1), 64'(1));
        check("t2_wr0_addr", 64'(wr_addr), 64'(1));
        check("t2_wr0_data", wr_data, 64'hAAAA);
        cyc(); valid1 = 1'b0;
        obs();
        check("t2_wr1_en", 64'(wr_en), 64'(1));
        check("t2_wr1_addr", 64'(wr_addr), 64'(2));
        check("t2_wr1_data", wr_data, 64'h5555);

        // Lock limit, then asynchronous reset mid-burst
        pulse_reset();
        valid0 = 1'b1; lock0 = 1'b1; req0.addr = 5'd4; req0.data = 64'h40;
        valid1 = 1'b1; lock1 = 1'b0; req1.addr = 5'd5; req1.data = 64'h50;
        for (int i = 0; i < 10; i++) begin
            obs();
            check("t3_grant_ready1", 64'(ready1), 64'(exp_seq[i]));
            check("t3_grant_ready0", 64'(ready0), 64'(exp_seq[i] == 0));
            cyc();
        end
        obs();
        check("t6_wr_en_before", 64'(wr_en), 64'(1));
        reset = 1'b1;
        #1;
        check("t6_wr_en_async", 64'(wr_en), 64'(0));
        check("t6_wr_addr_async", 64'(wr_addr), 64'(0));
        check("t6_no_grant_in_reset", 64'(ready0 | ready1), 64'(0));
        check("t6_model_hold", 64'(m_hold), 64'(0));
        #1; reset = 1'b0;
        #1;
        check("t6_first_ready0", 64'(ready0), 64'(1));
        check("t6_first_ready1", 64'(ready1), 64'(0));
        cyc(); valid0 = 1'b0; valid1 = 1'b0; lock0 = 1'b0;

        // XZR write
        cyc();
        valid1 = 1'b1; req1.addr = 5'd31; req1.data = 64'hFFFF_FFFF_FFFF_FFFF;
        obs();
        check("t4_ready1", 64'(ready1), 64'(1));
        cyc(); valid1 = 1'b0;
        obs();
        check("t4_wr_en", 64'(wr_en), 64'(0));
        check("t4_wr_addr", 64'(wr_addr), 64'(31));
        check("t4_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // Lock without contention, then req0 arrives
        cyc();
        valid1 = 1'b1; lock1 = 1'b1; req1.addr = 5'd7; req1.data = 64'h77;
        for (int i = 0; i < 10; i++) begin
            obs();
            check("t5_burst_ready1", 64'(ready1), 64'(1));
            cyc();
        end
        check("t5_model_hold", 64'(m_hold), 64'(MAX_HOLD));
        valid0 = 1'b1; req0.addr = 5'd8; req0.data = 64'h88;
        obs();
        check("t5_ready0", 64'(ready0), 64'(1));
        check("t5_ready1", 64'(ready1), 64'(0));
        cyc(); valid0 = 1'b0; valid1 = 1'b0; lock1 = 1'b0;
        obs();
        check("t5_wr_addr", 64'(wr_addr), 64'(8));
        obs();
        obs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
